// File: rtl/bcd_checker.sv
// rtl/bcd_checker.sv - registered multi-digit BCD validity checker
// Flags nibbles outside 0..9 and keeps a sticky error bit plus a saturating error count.
module bcd_checker #(
  parameter int DIGITS = 1,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  clr_err,
  output logic                  out_valid,
  output logic                  flag,
  output logic [DIGITS-1:0]     digit_ok,
  output logic                  err_sticky,
  output logic [CNT_W-1:0]      err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DIGITS-1:0] nib_ok;
  logic              word_ok;

  // A nibble is 10..15 exactly when b3 is set together with b2 or b1.
  for (genvar k = 0; k < DIGITS; k++) begin : g_nib
    assign nib_ok[k] = ~(data[4*k+3] & (data[4*k+2] | data[4*k+1]));
  end

  assign word_ok = &nib_ok;

  logic              out_valid_q, out_valid_d;
  logic              flag_q, flag_d;
  logic [DIGITS-1:0] digit_ok_q, digit_ok_d;
  logic              err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  always_comb begin
    out_valid_d  = in_valid;
    flag_d       = flag_q;
    digit_ok_d   = digit_ok_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    if (in_valid) begin
      flag_d     = word_ok;
      digit_ok_d = nib_ok;
      if (!word_ok) begin
        err_sticky_d = 1'b1;
        if (err_count_q != CNT_MAX) begin
          err_count_d = err_count_q + CNT_W'(1);
        end
      end
    end
    // Clearing takes priority over an error recorded in the same cycle.
    if (clr_err) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      flag_q       <= 1'b1;
      digit_ok_q   <= '1;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      flag_q       <= flag_d;
      digit_ok_q   <= digit_ok_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign flag       = flag_q;
  assign digit_ok   = digit_ok_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_bcd_checker.sv
// tb/tb_bcd_checker.sv - directed self-checking bench for bcd_checker
module tb_bcd_checker;

  logic clk;
  logic rst;

  logic        a_in_valid, a_clr_err, a_out_valid, a_flag, a_digit_ok, a_err_sticky;
  logic [3:0]  a_data;
  logic [7:0]  a_err_count;

  logic        b_in_valid, b_clr_err, b_out_valid, b_flag, b_err_sticky;
  logic [15:0] b_data;
  logic [3:0]  b_digit_ok;
  logic [7:0]  b_err_count;

  logic        c_in_valid, c_clr_err, c_out_valid, c_flag, c_digit_ok, c_err_sticky;
  logic [3:0]  c_data;
  logic [1:0]  c_err_count;

  int passed = 0;
  int total  = 0;

  bcd_checker #(.DIGITS(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .data(a_data), .clr_err(a_clr_err),
    .out_valid(a_out_valid), .flag(a_flag), .digit_ok(a_digit_ok),
    .err_sticky(a_err_sticky), .err_count(a_err_count)
  );

  bcd_checker #(.DIGITS(4), .CNT_W(8)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .data(b_data), .clr_err(b_clr_err),
    .out_valid(b_out_valid), .flag(b_flag), .digit_ok(b_digit_ok),
    .err_sticky(b_err_sticky), .err_count(b_err_count)
  );

  bcd_checker #(.DIGITS(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .data(c_data), .clr_err(c_clr_err),
    .out_valid(c_out_valid), .flag(c_flag), .digit_ok(c_digit_ok),
    .err_sticky(c_err_sticky), .err_count(c_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if ({a_out_valid, a_flag, a_digit_ok, a_err_sticky, a_err_count} !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd0})
      $display("FAIL reset_d1 got=%b exp=%b", {a_out_valid, a_flag, a_digit_ok, a_err_sticky, a_err_count}, {1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
    else passed++;
    total++; if ({b_out_valid, b_flag, b_digit_ok, b_err_sticky, b_err_count} !== {1'b0, 1'b1, 4'hF, 1'b0, 8'd0})
      $display("FAIL reset_d4 got=%b exp=%b", {b_out_valid, b_flag, b_digit_ok, b_err_sticky, b_err_count}, {1'b0, 1'b1, 4'hF, 1'b0, 8'd0});
    else passed++;
    total++; if ({c_out_valid, c_flag, c_digit_ok, c_err_sticky, c_err_count} !== {1'b0, 1'b1, 1'b1, 1'b0, 2'd0})
      $display("FAIL reset_sat got=%b exp=%b", {c_out_valid, c_flag, c_digit_ok, c_err_sticky, c_err_count}, {1'b0, 1'b1, 1'b1, 1'b0, 2'd0});
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    int exp_cnt;
    logic exp_ok;
    exp_cnt = 0;
    for (int v = 0; v < 16; v++) begin
      a_in_valid = 1'b1;
      a_data = 4'(v);
      tick();
      exp_ok = (v <= 9);
      if (!exp_ok) exp_cnt++;
      total++; if (a_out_valid !== 1'b1) $display("FAIL sweep_out_valid v=%0d got=%b exp=1", v, a_out_valid); else passed++;
      total++; if (a_flag !== exp_ok) $display("FAIL sweep_flag v=%0d got=%b exp=%b", v, a_flag, exp_ok); else passed++;
      total++; if (a_digit_ok !== exp_ok) $display("FAIL sweep_digit_ok v=%0d got=%b exp=%b", v, a_digit_ok, exp_ok); else passed++;
      total++; if (a_err_count !== 8'(exp_cnt)) $display("FAIL sweep_count v=%0d got=%0d exp=%0d", v, a_err_count, exp_cnt); else passed++;
    end
    a_in_valid = 1'b0;
    tick();
    total++; if (a_err_count !== 8'd6) $display("FAIL sweep_final_count got=%0d exp=6", a_err_count); else passed++;
    total++; if (a_err_sticky !== 1'b1) $display("FAIL sweep_final_sticky got=%b exp=1", a_err_sticky); else passed++;
    total++; if (a_out_valid !== 1'b0) $display("FAIL sweep_idle_out_valid got=%b exp=0", a_out_valid); else passed++;
  endtask

  task automatic test_hold();
    a_in_valid = 1'b1;
    a_data = 4'hB;
    tick();
    a_in_valid = 1'b0;
    a_data = 4'h3;
    tick();
    tick();
    total++; if (a_out_valid !== 1'b0) $display("FAIL hold_out_valid got=%b exp=0", a_out_valid); else passed++;
    total++; if (a_flag !== 1'b0) $display("FAIL hold_flag got=%b exp=0", a_flag); else passed++;
    total++; if (a_digit_ok !== 1'b0) $display("FAIL hold_digit_ok got=%b exp=0", a_digit_ok); else passed++;
    total++; if (a_err_count !== 8'd7) $display("FAIL hold_count got=%0d exp=7", a_err_count); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [4];
    logic [3:0]  exp_dok [4];
    logic [7:0]  exp_cnt [4];
    words   = '{16'h12A4, 16'h9999, 16'hFA09, 16'h0000};
    exp_dok = '{4'b1101, 4'b1111, 4'b0011, 4'b1111};
    exp_cnt = '{8'd1, 8'd1, 8'd2, 8'd2};
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_data = words[i];
      tick();
      total++; if (b_out_valid !== 1'b1) $display("FAIL b2b_out_valid i=%0d got=%b exp=1", i, b_out_valid); else passed++;
      total++; if (b_digit_ok !== exp_dok[i]) $display("FAIL b2b_digit_ok i=%0d got=%b exp=%b", i, b_digit_ok, exp_dok[i]); else passed++;
      total++; if (b_flag !== (exp_dok[i] == 4'hF)) $display("FAIL b2b_flag i=%0d got=%b exp=%b", i, b_flag, exp_dok[i] == 4'hF); else passed++;
      total++; if (b_err_count !== exp_cnt[i]) $display("FAIL b2b_count i=%0d got=%0d exp=%0d", i, b_err_count, exp_cnt[i]); else passed++;
    end
    b_in_valid = 1'b0;
    b_clr_err = 1'b1;
    b_data = 16'hAAAA;
    tick();
    b_clr_err = 1'b0;
    total++; if ({b_err_sticky, b_err_count} !== 9'd0) $display("FAIL idle_clear got=%b exp=0", {b_err_sticky, b_err_count}); else passed++;
    total++; if ({b_flag, b_digit_ok} !== 5'b11111) $display("FAIL idle_clear_hold got=%b exp=11111", {b_flag, b_digit_ok}); else passed++;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      c_in_valid = 1'b1;
      c_data = 4'hF;
      tick();
      total++; if (c_err_count !== exp_seq[i]) $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, c_err_count, exp_seq[i]); else passed++;
      total++; if (c_err_sticky !== 1'b1) $display("FAIL sat_sticky i=%0d got=%b exp=1", i, c_err_sticky); else passed++;
    end
    c_clr_err = 1'b1;
    tick();
    c_clr_err = 1'b0;
    c_in_valid = 1'b0;
    total++; if (c_err_count !== 2'd0) $display("FAIL clr_wins_count got=%0d exp=0", c_err_count); else passed++;
    total++; if (c_err_sticky !== 1'b0) $display("FAIL clr_wins_sticky got=%b exp=0", c_err_sticky); else passed++;
    total++; if ({c_out_valid, c_flag, c_digit_ok} !== 3'b100) $display("FAIL clr_wins_result got=%b exp=100", {c_out_valid, c_flag, c_digit_ok}); else passed++;
  endtask

  task automatic test_reset_midstream();
    a_in_valid = 1'b1;
    a_data = 4'hC;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_in_valid = 1'b0;
    total++; if ({a_out_valid, a_flag, a_digit_ok} !== 3'b011) $display("FAIL midrst_result got=%b exp=011", {a_out_valid, a_flag, a_digit_ok}); else passed++;
    total++; if ({a_err_sticky, a_err_count} !== 9'd0) $display("FAIL midrst_err got=%b exp=0", {a_err_sticky, a_err_count}); else passed++;
    tick();
    total++; if (a_out_valid !== 1'b0) $display("FAIL midrst_no_pulse got=%b exp=0", a_out_valid); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_data = 4'h0;  a_clr_err = 1'b0;
    b_in_valid = 1'b0; b_data = 16'h0; b_clr_err = 1'b0;
    c_in_valid = 1'b0; c_data = 4'h0;  c_clr_err = 1'b0;
    #1;
    test_reset();
    test_sweep();
    test_hold();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
